// File: rtl/clock_edit_ctrl.sv
// clock_edit_ctrl: debounced button front-end and view/edit sequencer for the counter control bus.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on PLUS/MINUS while editing.
module clock_edit_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_SCREENS     = 3,
  parameter int NUM_POS         = 6,
  parameter int TIMEOUT_CYCLES  = 2**20,
  parameter int REPEAT_DELAY    = 2**16,
  parameter int REPEAT_RATE     = 2**13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KeyModeRaw,
  input  logic       KeySetRaw,
  input  logic       KeyPlusRaw,
  input  logic       KeyMinusRaw,
  output logic [1:0] screen,
  output logic       EditMode,
  output logic [2:0] EditPos,
  output logic       KeyPlus,
  output logic       KeyMinus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || NUM_SCREENS > 4 || NUM_POS > 8 || REPEAT_RATE < 2 || REPEAT_DELAY < REPEAT_RATE)
    $error("clock_edit_ctrl: unsupported parameter set");
  typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_t;
  state_t state, state_n;
  logic [3:0] raw, s1, s2, stab, pe;
  logic [DW-1:0] cnt [4];
  logic [TW-1:0] tmo, tmo_n;
  logic [1:0] screen_n;
  logic [2:0] pos_n;
  logic kp_n, km_n;
  logic ev_mode, ev_set, ev_plus, ev_minus;
  logic rep_plus, rep_minus, rep;
  // bit order: 0=MODE 1=SET 2=PLUS 3=MINUS, all active-low
  assign raw = {KeyMinusRaw, KeyPlusRaw, KeySetRaw, KeyModeRaw};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
      stab <= '1;
      pe <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      pe <= '0;
      for (int k = 0; k < 4; k++)
        if (s2[k] == stab[k]) cnt[k] <= '0;
        else if (cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[k] <= '0;
          stab[k] <= s2[k];
          pe[k] <= ~s2[k];
        end else cnt[k] <= cnt[k] + 1'b1;
    end
  assign ev_set   = pe[1];
  assign ev_mode  = pe[0] & ~pe[1];
  assign ev_plus  = pe[2] & ~pe[3] & ~|pe[1:0];
  assign ev_minus = pe[3] & ~pe[2] & ~|pe[1:0];
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  logic [RW-1:0] rcnt;
  logic ract, rdir, held;
  assign held = rdir ? ~stab[2] : ~stab[3];
  assign rep = ract & held & (state == EDIT) & ~|pe & (rcnt == RW'(REPEAT_DELAY - 1));
  assign rep_plus = rep & rdir;
  assign rep_minus = rep & ~rdir;
  // after the first wrap the counter restarts REPEAT_RATE short of the limit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ract <= 1'b0;
      rdir <= 1'b0;
      rcnt <= '0;
    end else if (state == EDIT && (ev_plus || ev_minus)) begin
      ract <= 1'b1;
      rdir <= ev_plus;
      rcnt <= '0;
    end else if (!ract || state != EDIT || !held || |pe) ract <= 1'b0;
    else rcnt <= (rcnt == RW'(REPEAT_DELAY - 1)) ? RW'(REPEAT_DELAY - REPEAT_RATE) : rcnt + 1'b1;
`else
  assign rep_plus = 1'b0;
  assign rep_minus = 1'b0;
  assign rep = 1'b0;
`endif
  always_comb begin
    state_n = state;
    screen_n = screen;
    pos_n = EditPos;
    tmo_n = '0;
    kp_n = 1'b1;
    km_n = 1'b1;
    if (state == VIEW) begin
      if (ev_set) state_n = EDIT;
      else if (ev_mode) screen_n = (screen == 2'(NUM_SCREENS - 1)) ? 2'd0 : screen + 2'd1;
    end else begin
      kp_n = ~(ev_plus | rep_plus);
      km_n = ~(ev_minus | rep_minus);
      tmo_n = (|pe || rep) ? '0 : tmo + 1'b1;
      if ((ev_set && EditPos == 3'(NUM_POS - 1)) || ev_mode || (tmo == TW'(TIMEOUT_CYCLES - 1) && !(|pe || rep))) begin
        state_n = VIEW;
        pos_n = '0;
      end else if (ev_set) pos_n = EditPos + 3'd1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= VIEW;
      screen <= '0;
      EditPos <= '0;
      tmo <= '0;
      KeyPlus <= 1'b1;
      KeyMinus <= 1'b1;
    end else begin
      state <= state_n;
      screen <= screen_n;
      EditPos <= pos_n;
      tmo <= tmo_n;
      KeyPlus <= kp_n;
      KeyMinus <= km_n;
    end
  assign EditMode = (state == EDIT);
endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb_clock_edit_ctrl: directed bench; strobe expectations are queued at stimulus time and checked every cycle.
module tb_clock_edit_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] keys = 4'hF;
  logic [1:0] screen;
  logic EditMode, KeyPlus, KeyMinus;
  logic [2:0] EditPos;
  int cyc = 0, tests = 0, fails = 0, s = 0;
  logic mon_en = 1'b0;
  typedef struct {int kind; int cyc;} exp_t;
  exp_t q[$];
  localparam logic [3:0] MODE = 4'b0001, SET = 4'b0010, PLUS = 4'b0100, MINUS = 4'b1000;

  clock_edit_ctrl #(.DEBOUNCE_CYCLES(4), .NUM_SCREENS(3), .NUM_POS(6), .TIMEOUT_CYCLES(64),
                    .REPEAT_DELAY(16), .REPEAT_RATE(8)) dut (
    .clk(clk), .reset(reset),
    .KeyModeRaw(keys[0]), .KeySetRaw(keys[1]), .KeyPlusRaw(keys[2]), .KeyMinusRaw(keys[3]),
    .screen(screen), .EditMode(EditMode), .EditPos(EditPos), .KeyPlus(KeyPlus), .KeyMinus(KeyMinus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe scoreboard: each cycle the queue head says whether a low strobe is due now
  always @(negedge clk) begin
    logic ep, em;
    if (mon_en && reset) begin
      ep = 1'b1;
      em = 1'b1;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ep = (q[0].kind == 1) ? 1'b0 : 1'b1;
        em = (q[0].kind == 2) ? 1'b0 : 1'b1;
        q.delete(0);
      end
      tests += 2;
      assert (KeyPlus === ep) else begin fails++; $error("FAIL KeyPlus@%0d: observed %b expected %b", cyc, KeyPlus, ep); end
      assert (KeyMinus === em) else begin fails++; $error("FAIL KeyMinus@%0d: observed %b expected %b", cyc, KeyMinus, em); end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin fails++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int kind);
    @(negedge clk);
    keys = ~mask;
    if (kind != 0) q.push_back('{kind, cyc + 7});
    repeat (hold) @(negedge clk);
    keys = 4'hF;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst screen", screen, 0);
    chk("rst EditMode", EditMode, 0);
    chk("rst EditPos", EditPos, 0);
    chk("rst KeyPlus", KeyPlus, 1);
    chk("rst KeyMinus", KeyMinus, 1);
    press(PLUS, 10, 0);
    chk("view plus EditMode", EditMode, 0);
    press(MODE, 10, 0); chk("screen 1", screen, 1);
    press(MODE, 10, 0); chk("screen 2", screen, 2);
    press(MODE, 10, 0); chk("screen 0", screen, 0);
    press(MODE, 10, 0); chk("screen 1b", screen, 1);
    press(SET, 10, 0);
    chk("walk enter", EditMode, 1);
    chk("walk pos0", EditPos, 0);
    for (int i = 1; i < 6; i++) begin
      press(SET, 10, 0);
      chk("walk pos", EditPos, i);
      chk("walk mode", EditMode, 1);
    end
    press(SET, 10, 0);
    chk("walk exit", EditMode, 0);
    chk("walk exit pos", EditPos, 0);
    chk("walk screen", screen, 1);
    press(SET, 10, 0);
    for (int i = 0; i < 3; i++) press(SET, 10, 0);
    chk("cancel pos3", EditPos, 3);
    press(MODE, 10, 0);
    chk("cancel EditMode", EditMode, 0);
    chk("cancel EditPos", EditPos, 0);
    chk("cancel screen", screen, 1);
    press(SET, 10, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); keys[2] = 1'b0;
      @(negedge clk);
      @(negedge clk); keys[2] = 1'b1;
      @(negedge clk);
    end
    press(PLUS, 10, 1);
    press(MINUS, 10, 2);
    chk("debounce EditMode", EditMode, 1);
    repeat (80) @(negedge clk);
    chk("idle exit", EditMode, 0);
    @(negedge clk);
    s = cyc;
    keys[1] = 1'b0;
    repeat (10) @(negedge clk);
    keys = 4'hF;
    wait_cyc(s + 70); chk("timeout 63", EditMode, 1);
    wait_cyc(s + 71); chk("timeout 64", EditMode, 0);
    @(negedge clk);
    s = cyc;
    keys[1] = 1'b0;
    repeat (10) @(negedge clk);
    keys = 4'hF;
    wait_cyc(s + 7 + 33);
    keys[2] = 1'b0;
    q.push_back('{1, s + 7 + 40});
    repeat (10) @(negedge clk);
    keys = 4'hF;
    wait_cyc(s + 7 + 64); chk("timeout held off", EditMode, 1);
    wait_cyc(s + 7 + 103); chk("timeout late 103", EditMode, 1);
    wait_cyc(s + 7 + 104); chk("timeout late 104", EditMode, 0);
    press(SET, 10, 0);
    press(PLUS | MINUS, 10, 0);
    chk("plus+minus pos", EditPos, 0);
    press(SET | PLUS, 10, 0);
    chk("set+plus pos", EditPos, 1);
    chk("set+plus mode", EditMode, 1);
    mon_en = 1'b0;
    @(negedge clk);
    s = cyc;
    keys[3] = 1'b0;
    wait_cyc(s + 6); chk("pre pulse KeyMinus", KeyMinus, 1);
    wait_cyc(s + 7); chk("pulse KeyMinus", KeyMinus, 0);
    #2 reset = 1'b0;
    #1;
    chk("async KeyMinus", KeyMinus, 1);
    chk("async EditMode", EditMode, 0);
    chk("async EditPos", EditPos, 0);
    keys = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    press(SET, 10, 0);
    @(negedge clk);
    s = cyc;
    keys[2] = 1'b0;
    q.push_back('{1, s + 7});
`ifdef AUTO_REPEAT_EN
    q.push_back('{1, s + 23});
    q.push_back('{1, s + 31});
    q.push_back('{1, s + 39});
`endif
    repeat (40) @(negedge clk);
    keys = 4'hF;
    repeat (15) @(negedge clk);
    chk("repeat EditMode", EditMode, 1);
    chk("queue drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
